// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model backing the dcache master port in core-level simulation.
// Independent read and write FSMs, each serving one INCR burst at a time from a word array.
module axi_mem_responder #(
   parameter int unsigned ID_WIDTH   = 13,
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned MEM_WORDS  = 1024
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [ID_WIDTH-1:0]       s_axi_awid,
   input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic [7:0]                s_axi_awlen,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                      s_axi_wlast,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   output logic [ID_WIDTH-1:0]       s_axi_bid,
   output logic [1:0]                s_axi_bresp,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready,
   input  logic [ID_WIDTH-1:0]       s_axi_arid,
   input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic [7:0]                s_axi_arlen,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   output logic [ID_WIDTH-1:0]       s_axi_rid,
   output logic [DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                s_axi_rresp,
   output logic                      s_axi_rlast,
   output logic                      s_axi_rvalid,
   input  logic                      s_axi_rready
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned OFS_W      = $clog2(STRB_WIDTH);
   localparam int unsigned IDX_W      = $clog2(MEM_WORDS);
   localparam logic [1:0]  RESP_OKAY  = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_DATA}         r_state_t;

   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

   w_state_t              w_state, w_next;
   logic [ID_WIDTH-1:0]   w_id;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic [7:0]            w_len, w_cnt;
   logic                  w_err;
   logic                  aw_hs, w_hs, b_hs, w_in_range, w_last_beat;
   logic                  awready_d, wready_d, bvalid_d;

   r_state_t              r_state, r_next;
   logic [ADDR_WIDTH-1:0] r_idx, r_load_idx;
   logic [7:0]            r_len, r_cnt;
   logic                  ar_hs, r_hs, r_load_ok;
   logic [DATA_WIDTH-1:0] r_load_data;
   logic                  arready_d, rvalid_d;

   assign aw_hs       = s_axi_awvalid && s_axi_awready;
   assign w_hs        = s_axi_wvalid && s_axi_wready;
   assign b_hs        = s_axi_bvalid && s_axi_bready;
   assign w_in_range  = w_idx < ADDR_WIDTH'(MEM_WORDS);
   assign w_last_beat = (w_cnt == w_len);

   // Write FSM state register
   always_ff @(posedge clk) begin
      if (reset) w_state <= W_IDLE;
      else       w_state <= w_next;
   end

   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE:  if (aw_hs) w_next = W_DATA;
         W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
         W_RESP:  if (b_hs) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   // Handshake outputs are registered from the next state so they drop to zero during reset
   always_comb begin
      awready_d = 1'b0;
      wready_d  = 1'b0;
      bvalid_d  = 1'b0;
      case (w_next)
         W_IDLE:  awready_d = 1'b1;
         W_DATA:  wready_d  = 1'b1;
         W_RESP:  bvalid_d  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
         s_axi_bvalid  <= 1'b0;
         w_id          <= '0;
         w_idx         <= '0;
         w_len         <= '0;
         w_cnt         <= '0;
         w_err         <= 1'b0;
      end else begin
         s_axi_awready <= awready_d;
         s_axi_wready  <= wready_d;
         s_axi_bvalid  <= bvalid_d;
         if (aw_hs) begin
            w_id  <= s_axi_awid;
            w_idx <= ADDR_WIDTH'(s_axi_awaddr >> OFS_W);
            w_len <= s_axi_awlen;
            w_cnt <= '0;
            w_err <= 1'b0;
         end else if (w_hs) begin
            w_idx <= w_idx + ADDR_WIDTH'(1);
            w_cnt <= w_cnt + 8'd1;
            if (!w_in_range || (s_axi_wlast != w_last_beat)) w_err <= 1'b1;
         end
      end
   end

   assign s_axi_bid   = w_id;
   assign s_axi_bresp = w_err ? RESP_SLVERR : RESP_OKAY;

   // Byte-enabled store; out-of-range beats are dropped
   always_ff @(posedge clk) begin
      if (!reset && w_hs && w_in_range) begin
         for (int i = 0; i < int'(STRB_WIDTH); i++) begin
            if (s_axi_wstrb[i]) mem[w_idx[IDX_W-1:0]][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
         end
      end
   end

   assign ar_hs = s_axi_arvalid && s_axi_arready;
   assign r_hs  = s_axi_rvalid && s_axi_rready;

   // Read FSM state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= R_IDLE;
      else       r_state <= r_next;
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_next = R_DATA;
         R_DATA:  if (r_hs && s_axi_rlast) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_comb begin
      arready_d = (r_next == R_IDLE);
      rvalid_d  = (r_next == R_DATA);
   end

   // Array read sees pre-write contents when a store lands on the same edge
   always_comb begin
      r_load_idx  = ar_hs ? ADDR_WIDTH'(s_axi_araddr >> OFS_W) : r_idx + ADDR_WIDTH'(1);
      r_load_ok   = r_load_idx < ADDR_WIDTH'(MEM_WORDS);
      r_load_data = r_load_ok ? mem[r_load_idx[IDX_W-1:0]] : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s_axi_arready <= 1'b0;
         s_axi_rvalid  <= 1'b0;
         s_axi_rid     <= '0;
         s_axi_rdata   <= '0;
         s_axi_rresp   <= RESP_OKAY;
         s_axi_rlast   <= 1'b0;
         r_idx         <= '0;
         r_len         <= '0;
         r_cnt         <= '0;
      end else begin
         s_axi_arready <= arready_d;
         s_axi_rvalid  <= rvalid_d;
         if (ar_hs) begin
            s_axi_rid   <= s_axi_arid;
            r_len       <= s_axi_arlen;
            r_cnt       <= '0;
            r_idx       <= r_load_idx;
            s_axi_rdata <= r_load_data;
            s_axi_rresp <= r_load_ok ? RESP_OKAY : RESP_SLVERR;
            s_axi_rlast <= (s_axi_arlen == 8'd0);
         end else if (r_hs && !s_axi_rlast) begin
            r_cnt       <= r_cnt + 8'd1;
            r_idx       <= r_load_idx;
            s_axi_rdata <= r_load_data;
            s_axi_rresp <= r_load_ok ? RESP_OKAY : RESP_SLVERR;
            s_axi_rlast <= (8'(r_cnt + 8'd1) == r_len);
         end
      end
   end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: burst writes/reads, strobes, range errors,
// wlast mismatch and mid-burst reset.
module tb_axi_mem_responder;

   localparam int unsigned ID_W  = 13;
   localparam int unsigned AW    = 64;
   localparam int unsigned DW    = 64;
   localparam int unsigned WORDS = 1024;
   localparam int          LIMIT = 50;

   logic            clk = 1'b0;
   logic            reset;
   logic [ID_W-1:0] awid, bid, arid, rid;
   logic [AW-1:0]   awaddr, araddr;
   logic [7:0]      awlen, arlen;
   logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic [DW-1:0]   wdata, rdata;
   logic [DW/8-1:0] wstrb;
   logic [1:0]      bresp, rresp;
   logic            arvalid, arready, rlast, rvalid, rready;

   int checks   = 0;
   int failures = 0;

   logic [63:0]     wd [4];
   logic [7:0]      ws [4];
   logic            wl [4];
   logic [63:0]     rd_data [8];
   logic [1:0]      rd_resp [8];
   logic            rd_last [8];
   int              rd_n;
   logic [1:0]      b_resp;
   logic [ID_W-1:0] b_id, r_id;

   always #5 clk = ~clk;

   axi_mem_responder #(.ID_WIDTH(ID_W), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(WORDS)) dut (
      .clk(clk), .reset(reset),
      .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
      .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
      .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
      .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
      .s_axi_rvalid(rvalid), .s_axi_rready(rready)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Full write burst; call on a negedge, returns on a negedge
   task automatic axi_write(input logic [ID_W-1:0] id, input logic [AW-1:0] addr,
                            input logic [7:0] len, input int nbeats);
      int n;
      awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
      n = 0;
      while (!awready && n < LIMIT) begin @(negedge clk); n++; end
      check("aw_wait", 64'(n < LIMIT), 64'(1));
      @(negedge clk);
      awvalid = 1'b0;
      for (int b = 0; b < nbeats; b++) begin
         wdata = wd[b]; wstrb = ws[b]; wlast = wl[b]; wvalid = 1'b1;
         n = 0;
         while (!wready && n < LIMIT) begin @(negedge clk); n++; end
         check("w_wait", 64'(n < LIMIT), 64'(1));
         @(negedge clk);
      end
      wvalid = 1'b0; wlast = 1'b0;
      n = 0;
      while (!bvalid && n < LIMIT) begin @(negedge clk); n++; end
      check("b_wait", 64'(n < LIMIT), 64'(1));
      b_resp = bresp; b_id = bid; bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
   endtask

   // AR handshake; returns on the negedge just after the accepting edge
   task automatic ar_issue(input logic [ID_W-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
      int n;
      arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
      n = 0;
      while (!arready && n < LIMIT) begin @(negedge clk); n++; end
      check("ar_wait", 64'(n < LIMIT), 64'(1));
      @(negedge clk);
      arvalid = 1'b0;
      check("rvalid_latency", 64'(rvalid), 64'(1));
   endtask

   // Collect a read burst; toggle=1 alternates rready 1,0,1,0 and checks beats hold while stalled
   task automatic axi_read(input logic [ID_W-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len, input bit toggle);
      int   n;
      bit   done, hold_pending;
      logic [63:0] held;
      logic held_last;
      ar_issue(id, addr, len);
      r_id = rid;
      rd_n = 0; done = 1'b0; hold_pending = 1'b0; n = 0;
      held = '0; held_last = 1'b0;
      while (!done && n < 4 * LIMIT) begin
         rready = toggle ? ((n % 2) == 0) : 1'b1;
         if (hold_pending) begin
            check("r_hold_data", rdata, held);
            check("r_hold_last", 64'(rlast), 64'(held_last));
            hold_pending = 1'b0;
         end
         if (rvalid) begin
            if (rready) begin
               if (rd_n < 8) begin
                  rd_data[rd_n] = rdata; rd_resp[rd_n] = rresp; rd_last[rd_n] = rlast;
               end
               rd_n++;
               if (rlast) done = 1'b1;
            end else begin
               held = rdata; held_last = rlast; hold_pending = 1'b1;
            end
         end
         n++;
         @(negedge clk);
      end
      rready = 1'b0;
      check("r_done", 64'(done), 64'(1));
   endtask

   initial begin
      reset = 1'b1;
      awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
      b_resp = '0; b_id = '0; r_id = '0; rd_n = 0;
      repeat (3) @(negedge clk);

      check("rst_awready", 64'(awready), 64'(0));
      check("rst_arready", 64'(arready), 64'(0));
      check("rst_wready",  64'(wready),  64'(0));
      check("rst_bvalid",  64'(bvalid),  64'(0));
      check("rst_rvalid",  64'(rvalid),  64'(0));
      check("rst_bid_bresp", 64'({bid, bresp}), 64'(0));
      check("rst_r_outs", 64'({rid, rresp, rlast}), 64'(0));
      check("rst_rdata", rdata, 64'(0));
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_awready", 64'(awready), 64'(1));
      check("post_rst_arready", 64'(arready), 64'(1));

      // Single beat at 0x10
      wd[0] = 64'h1122334455667788; ws[0] = 8'hFF; wl[0] = 1'b1;
      axi_write(13'h5, 64'h10, 8'd0, 1);
      check("t1_bresp", 64'(b_resp), 64'(0));
      check("t1_bid", 64'(b_id), 64'(13'h5));
      axi_read(13'h7, 64'h10, 8'd0, 1'b0);
      check("t1_rid", 64'(r_id), 64'(13'h7));
      check("t1_nbeats", 64'(rd_n), 64'(1));
      check("t1_rdata", rd_data[0], 64'h1122334455667788);
      check("t1_rlast", 64'(rd_last[0]), 64'(1));
      check("t1_rresp", 64'(rd_resp[0]), 64'(0));

      // Four beats at 0x40, read back with rready toggling
      for (int i = 0; i < 4; i++) begin
         wd[i] = 64'(i + 1); ws[i] = 8'hFF; wl[i] = (i == 3);
      end
      axi_write(13'h1, 64'h40, 8'd3, 4);
      check("t2_bresp", 64'(b_resp), 64'(0));
      axi_read(13'h2, 64'h40, 8'd3, 1'b1);
      check("t2_nbeats", 64'(rd_n), 64'(4));
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t2_rdata%0d", i), rd_data[i], 64'(i + 1));
         check($sformatf("t2_rlast%0d", i), 64'(rd_last[i]), 64'(i == 3));
         check($sformatf("t2_rresp%0d", i), 64'(rd_resp[i]), 64'(0));
      end

      // Partial strobe merge
      wd[0] = 64'hFFFFFFFFFFFFFFFF; ws[0] = 8'hFF; wl[0] = 1'b1;
      axi_write(13'h3, 64'h80, 8'd0, 1);
      wd[0] = 64'hAAAAAAAABBBBBBBB; ws[0] = 8'h0F;
      axi_write(13'h3, 64'h80, 8'd0, 1);
      check("t3_bresp", 64'(b_resp), 64'(0));
      axi_read(13'h4, 64'h80, 8'd0, 1'b0);
      check("t3_rdata", rd_data[0], 64'hFFFFFFFFBBBBBBBB);

      // Burst running off the end of memory
      wd[0] = 64'h5555; wd[1] = 64'h6666; ws[0] = 8'hFF; ws[1] = 8'hFF; wl[0] = 1'b0; wl[1] = 1'b1;
      axi_write(13'h9, 64'(WORDS * 8 - 8), 8'd1, 2);
      check("t4_bresp", 64'(b_resp), 64'(2));
      axi_read(13'hA, 64'(WORDS * 8 - 8), 8'd1, 1'b0);
      check("t4_nbeats", 64'(rd_n), 64'(2));
      check("t4_rdata0", rd_data[0], 64'h5555);
      check("t4_rresp0", 64'(rd_resp[0]), 64'(0));
      check("t4_rlast0", 64'(rd_last[0]), 64'(0));
      check("t4_rdata1", rd_data[1], 64'(0));
      check("t4_rresp1", 64'(rd_resp[1]), 64'(2));
      check("t4_rlast1", 64'(rd_last[1]), 64'(1));

      // Early wlast: both beats still accepted, error reported
      wd[0] = 64'h7; wd[1] = 64'h8; wl[0] = 1'b1; wl[1] = 1'b1;
      axi_write(13'hB, 64'h100, 8'd1, 2);
      check("t5_bresp", 64'(b_resp), 64'(2));
      axi_read(13'hC, 64'h100, 8'd1, 1'b0);
      check("t5_rdata0", rd_data[0], 64'h7);
      check("t5_rdata1", rd_data[1], 64'h8);

      // Reset while the second beat of a 4-beat read is on the bus
      ar_issue(13'hD, 64'h40, 8'd3);
      rready = 1'b1;
      check("t6_beat0", rdata, 64'h1);
      @(negedge clk);
      check("t6_beat1", rdata, 64'h2);
      reset = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      check("t6_rvalid", 64'(rvalid), 64'(0));
      check("t6_bvalid", 64'(bvalid), 64'(0));
      check("t6_arready_in_rst", 64'(arready), 64'(0));
      reset = 1'b0;
      @(negedge clk);
      check("t6_arready", 64'(arready), 64'(1));
      check("t6_awready", 64'(awready), 64'(1));
      check("t6_rvalid_after", 64'(rvalid), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_mem_responder.md
Name:
axi_mem_responder

Overview:
- AXI4 slave memory model: the responder end of the dcache_m_axi_* master interface driven by the dcache in the memory stage.
- Serves INCR bursts from a word array. Independent read and write FSMs, each with one transaction outstanding. Used as backing store in core-level simulation.

Parameters:
- ID_WIDTH, 13: width of AXI ID fields.
- ADDR_WIDTH, 64: byte-address width.
- DATA_WIDTH, 64: beat width. STRB_WIDTH = DATA_WIDTH/8.
- MEM_WORDS, 1024: number of DATA_WIDTH words. Valid byte range is 0 to MEM_WORDS*STRB_WIDTH-1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_axi_awid  in  ID_WIDTH  write ID
- s_axi_awaddr  in  ADDR_WIDTH  write start byte address
- s_axi_awlen  in  8  beats minus 1
- s_axi_awvalid  in  1  AW valid
- s_axi_awready  out  1  AW ready
- s_axi_wdata  in  DATA_WIDTH  write beat data
- s_axi_wstrb  in  STRB_WIDTH  byte enables
- s_axi_wlast  in  1  final beat marker
- s_axi_wvalid  in  1  W valid
- s_axi_wready  out  1  W ready
- s_axi_bid  out  ID_WIDTH  echoed AWID
- s_axi_bresp  out  2  OKAY=0, SLVERR=2
- s_axi_bvalid  out  1  B valid
- s_axi_bready  in  1  B ready
- s_axi_arid  in  ID_WIDTH  read ID
- s_axi_araddr  in  ADDR_WIDTH  read start byte address
- s_axi_arlen  in  8  beats minus 1
- s_axi_arvalid  in  1  AR valid
- s_axi_arready  out  1  AR ready
- s_axi_rid  out  ID_WIDTH  echoed ARID
- s_axi_rdata  out  DATA_WIDTH  read beat data
- s_axi_rresp  out  2  per-beat response, OKAY or SLVERR
- s_axi_rlast  out  1  final beat marker
- s_axi_rvalid  out  1  R valid
- s_axi_rready  in  1  R ready

Behaviour:
- Reset: all ready and valid outputs = 0; bid, bresp, rid, rdata, rresp and rlast = 0; both FSMs go to IDLE. Memory contents are not cleared. The cycle after reset deasserts, awready = arready = 1.
- Addressing: word index = addr / STRB_WIDTH; low address bits are ignored. Every beat is full-width INCR and the index increments by 1 per beat. A beat is out of range if its index >= MEM_WORDS. Index arithmetic is ADDR_WIDTH-bit and never wraps into range.
- Write FSM, W_IDLE: awready = 1. On the AW handshake, latch id, index and len; clear beat count and the error flag; go to W_DATA.
- W_DATA: wready = 1. On each W handshake, bytes with wstrb[i] = 1 are written to mem[index]. Out-of-range beats are dropped and set the error flag. The index increments and the count increments. wlast must equal (count == len); a mismatch sets the error flag. On the beat where count == len, go to W_RESP regardless of wlast.
- W_RESP: bvalid = 1, bid = latched id, bresp = SLVERR if the error flag is set, else OKAY. On the bready handshake, go to W_IDLE. awready = wready = 0 outside their states.
- Read FSM, R_IDLE: arready = 1. On the AR handshake, latch id and len, and load mem[index] into rdata. If out of range, rdata = 0 and rresp = SLVERR. Go to R_DATA. The first rvalid rises the cycle after the AR handshake.
- R_DATA: rvalid = 1, rlast = (count == len). rdata, rresp and rlast are held stable while rready = 0. On the R handshake with rlast = 1, go to R_IDLE and clear rvalid. Otherwise load the next word in that same cycle, giving back-to-back beats.
- Simultaneous write and read to the same word in one cycle: the read load samples old data. The write is visible to loads from the next cycle on.
- The read and write FSMs run concurrently with no ordering between channels. A reset mid-burst aborts both bursts immediately.

Test Plan:
- Write single beat addr 0x10, wdata 0x1122334455667788, wstrb 0xFF; read addr 0x10 -> bresp=0; rdata=0x1122334455667788, rlast=1, rresp=0.
- Write 4 beats (awlen=3) at 0x40 with data 1,2,3,4, then read awlen=3 at 0x40 with rready toggling 1,0,1,0 -> beats 1,2,3,4 in order, each held stable while rready=0, rlast only on beat 4.
- Write wstrb 0x0F data 0xAAAAAAAABBBBBBBB over word 0xFFFFFFFFFFFFFFFF -> read returns 0xFFFFFFFFBBBBBBBB.
- Read at addr MEM_WORDS*8 - 8 with arlen=1 -> beat 0 has rresp=0; beat 1 has rresp=2 and rdata=0. Write of the same shape -> bresp=2, and the in-range word is updated.
- Write with awlen=1 and wlast=1 on beat 0 -> 2 beats accepted, bresp=2. Assert reset during the second beat of a 4-beat read -> next cycle rvalid=0, bvalid=0; arready=1 one cycle after reset deasserts.
